// File: rtl/bloom_filter_ctrl.sv
// Bloom filter controller.
// Keeps a 2^HASH_W-bit membership array in an external single-port 32-bit
// BRAM, walks NUM_HASH hash positions per key one word at a time, and answers
// query (test all bits) or insert (read-modify-write all bits) requests.
// The array is swept to zero after reset and on clear_req from IDLE.
module bloom_filter_ctrl #(
    parameter int DATA_W   = 72,
    parameter int NUM_HASH = 7,
    parameter int HASH_W   = 11,
    localparam int ADDR_W  = HASH_W - 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_req,
    output logic                       clear_done,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_hit,
    output logic [DATA_W-1:0]          hash_key,
    input  logic [NUM_HASH*HASH_W-1:0] hash_in,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [31:0]                bram_wdata,
    input  logic [31:0]                bram_rdata,
    output logic                       busy,
    output logic [15:0]                insert_count
);

    localparam int K_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [K_W-1:0]    LAST_K    = K_W'(NUM_HASH - 1);

    typedef enum logic [2:0] {
        CLR  = 3'd0,
        IDLE = 3'd1,
        HASH = 3'd2,
        RD   = 3'd3,
        CHK  = 3'd4,
        WR   = 3'd5,
        RESP = 3'd6
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [ADDR_W-1:0]   clr_addr_reg;
    logic [DATA_W-1:0]   key_reg;
    logic                op_reg;
    logic [HASH_W-1:0]   hash_reg [NUM_HASH];
    logic [K_W-1:0]      k_reg;
    logic [31:0]         rdata_reg;
    logic                flag_reg;
    logic                hit_reg;
    logic [15:0]         insert_count_reg;

    // Currently selected hash split into word address and bit-in-word.
    logic [HASH_W-1:0]   cur_hash;
    logic [ADDR_W-1:0]   cur_word;
    logic [4:0]          cur_bit;
    logic                rd_bit;
    logic                k_last;

    // Raw (pre-reset-gating) BRAM and clear-done drives.
    logic                bram_en_raw;
    logic                bram_we_raw;
    logic                clear_done_raw;

    assign cur_hash = hash_reg[k_reg];
    assign cur_word = cur_hash[HASH_W-1:5];
    assign cur_bit  = cur_hash[4:0];
    assign rd_bit   = bram_rdata[cur_bit];
    assign k_last   = (k_reg == LAST_K);

    // Capture every hash lane from the external hash unit while in HASH.
    generate
        for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_hash_cap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hash_reg[gi] <= '0;
                end else if (state_reg == HASH) begin
                    hash_reg[gi] <= hash_in[gi*HASH_W +: HASH_W];
                end
            end
        end
    endgenerate

    // State register; reset lands in CLR so the sweep starts on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection and BRAM port drive for the current state.
    always_comb begin
        state_next     = state_reg;
        bram_en_raw    = 1'b0;
        bram_we_raw    = 1'b0;
        bram_addr      = '0;
        bram_wdata     = 32'h0;
        clear_done_raw = 1'b0;
        case (state_reg)
            CLR: begin
                bram_en_raw = 1'b1;
                bram_we_raw = 1'b1;
                bram_addr   = clr_addr_reg;
                if (clr_addr_reg == LAST_ADDR) begin
                    clear_done_raw = 1'b1;
                    state_next     = IDLE;
                end
            end
            IDLE: begin
                // A pending clear takes priority over a key request.
                if (clear_req) begin
                    state_next = CLR;
                end else if (req_valid) begin
                    state_next = HASH;
                end
            end
            HASH: begin
                state_next = RD;
            end
            RD: begin
                bram_en_raw = 1'b1;
                bram_addr   = cur_word;
                state_next  = CHK;
            end
            CHK: begin
                if (op_reg) begin
                    state_next = WR;
                end else if (!rd_bit || k_last) begin
                    state_next = RESP;
                end else begin
                    state_next = RD;
                end
            end
            WR: begin
                bram_en_raw = 1'b1;
                bram_we_raw = 1'b1;
                bram_addr   = cur_word;
                bram_wdata  = rdata_reg | (32'd1 << cur_bit);
                state_next  = k_last ? RESP : RD;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLR;
            end
        endcase
    end

    // Per-request datapath: key/op latch, hash index walk, read word, hit flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_reg <= '0;
            key_reg      <= '0;
            op_reg       <= 1'b0;
            k_reg        <= '0;
            rdata_reg    <= 32'h0;
            flag_reg     <= 1'b0;
            hit_reg      <= 1'b0;
        end else begin
            case (state_reg)
                CLR: begin
                    // Wraps back to zero after the last word, ready for the next sweep.
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                end
                IDLE: begin
                    if (!clear_req && req_valid) begin
                        key_reg <= req_data;
                        op_reg  <= req_op;
                    end
                end
                HASH: begin
                    k_reg    <= '0;
                    flag_reg <= 1'b1;
                end
                CHK: begin
                    rdata_reg <= bram_rdata;
                    if (op_reg) begin
                        flag_reg <= flag_reg & rd_bit;
                    end else if (!rd_bit) begin
                        hit_reg <= 1'b0;
                    end else if (k_last) begin
                        hit_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                WR: begin
                    if (k_last) begin
                        hit_reg <= flag_reg;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completed-insert counter: zeroed by any clear sweep, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insert_count_reg <= 16'h0;
        end else if (state_reg == CLR) begin
            insert_count_reg <= 16'h0;
        end else if (state_reg == RESP && resp_ready && op_reg &&
                     insert_count_reg != 16'hFFFF) begin
            insert_count_reg <= insert_count_reg + 16'd1;
        end
    end

    // Reset holds the state in CLR, so the write strobes and the done pulse are
    // masked while rst_n is low to keep the BRAM untouched during reset.
    assign bram_en      = bram_en_raw & rst_n;
    assign bram_we      = bram_we_raw & rst_n;
    assign clear_done   = clear_done_raw & rst_n;

    assign req_ready    = (state_reg == IDLE) && !clear_req;
    assign resp_valid   = (state_reg == RESP);
    assign resp_hit     = hit_reg;
    assign busy         = (state_reg != IDLE);
    assign hash_key     = key_reg;
    assign insert_count = insert_count_reg;

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// Self-checking bench for bloom_filter_ctrl: BRAM and hash-unit models,
// a set-of-bits reference model, directed cases and randomized key traffic.
module tb_bloom_filter_ctrl;

    localparam int DATA_W   = 72;
    localparam int NUM_HASH = 7;
    localparam int HASH_W   = 11;
    localparam int ADDR_W   = HASH_W - 5;
    localparam int NBITS    = 1 << HASH_W;
    localparam int NWORDS   = 1 << ADDR_W;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       clear_req = 1'b0;
    logic                       clear_done;
    logic                       req_valid = 1'b0;
    logic                       req_ready;
    logic                       req_op = 1'b0;
    logic [DATA_W-1:0]          req_data = '0;
    logic                       resp_valid;
    logic                       resp_ready = 1'b0;
    logic                       resp_hit;
    logic [DATA_W-1:0]          hash_key;
    logic [NUM_HASH*HASH_W-1:0] hash_in;
    logic                       bram_en;
    logic                       bram_we;
    logic [ADDR_W-1:0]          bram_addr;
    logic [31:0]                bram_wdata;
    logic [31:0]                bram_rdata;
    logic                       busy;
    logic [15:0]                insert_count;

    logic stub = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_hit = 1'b0;

    always #5 clk = ~clk;

    bloom_filter_ctrl #(
        .DATA_W(DATA_W), .NUM_HASH(NUM_HASH), .HASH_W(HASH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .clear_req(clear_req), .clear_done(clear_done),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .hash_key(hash_key), .hash_in(hash_in),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .busy(busy), .insert_count(insert_count)
    );

    // External BRAM: registered read, write counters for RMW accounting.
    logic [31:0] mem [NWORDS];
    int wr_total = 0;
    int wr63_total = 0;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_wdata;
                wr_total <= wr_total + 1;
                if (bram_addr == ADDR_W'(NWORDS - 1)) wr63_total <= wr63_total + 1;
            end else begin
                bram_rdata <= mem[bram_addr];
            end
        end
    end

    // External hash unit (or a stub driving every lane to the top bit).
    function automatic logic [HASH_W-1:0] hfn(input logic [DATA_W-1:0] key, input int k);
        logic [DATA_W-1:0] x;
        logic [HASH_W-1:0] h;
        x = key ^ ({8'h5A, 64'h9E3779B97F4A7C15} * DATA_W'(k + 1));
        x = x ^ (x >> 23) ^ (x << 17);
        h = HASH_W'(k * 97);
        for (int i = 0; i < 6; i++) h ^= x[i*11 +: 11];
        h ^= {5'd0, x[71:66]};
        return h;
    endfunction

    function automatic logic [HASH_W-1:0] get_h(input logic [DATA_W-1:0] key, input int k);
        return stub ? 11'h7FF : hfn(key, k);
    endfunction

    always_comb begin
        hash_in = '0;
        for (int k = 0; k < NUM_HASH; k++) hash_in[k*HASH_W +: HASH_W] = get_h(hash_key, k);
    end

    // Reference model: the bit set and the insert counter.
    bit model_bits [NBITS];
    int model_count = 0;

    task automatic model_clear();
        foreach (model_bits[i]) model_bits[i] = 1'b0;
        model_count = 0;
    endtask

    task automatic chk(input bit ok, input string name, input longint got, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle compare: a visible response must carry the model's hit value,
    // and the request side may only be open while idle.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (resp_valid) begin
                chk(resp_hit == mon_hit, "mon_resp_hit", resp_hit, mon_hit);
                chk(!req_ready, "mon_ready_during_resp", req_ready, 0);
            end
            if (req_ready) chk(!busy, "mon_busy_when_ready", busy, 0);
        end
    end

    task automatic check_reset_outputs(input string name);
        chk({busy, resp_valid, resp_hit, clear_done, bram_en, bram_we} == 6'b100000,
            name, {busy, resp_valid, resp_hit, clear_done, bram_en, bram_we}, 6'b100000);
        chk(insert_count == 16'h0, "reset_insert_count", insert_count, 0);
    endtask

    // Caller positions time so the next falling edge lies in sweep cycle 0.
    task automatic check_sweep(input bit drop_clear);
        int bad;
        bad = 0;
        for (int i = 0; i < NWORDS; i++) begin
            @(negedge clk);
            if (i == 0 && drop_clear) clear_req = 1'b0;
            #1;
            if (!(bram_en && bram_we && bram_addr == ADDR_W'(i) && bram_wdata == 32'h0 &&
                  busy && !resp_valid && !req_ready)) bad++;
            if (i > 0 && insert_count != 16'h0) bad++;
            if (clear_done !== (i == NWORDS - 1)) bad++;
        end
        chk(bad == 0, "clear_sweep", bad, 0);
        @(negedge clk);
        #1;
        chk(req_ready && !clear_done && !bram_en, "ready_after_clear",
            {req_ready, clear_done, bram_en}, 3'b100);
        model_clear();
    endtask

    task automatic do_op(input logic op, input logic [DATA_W-1:0] key, input int hold,
                         output logic got_hit, output int got_lat);
        logic exp_hit;
        int   exp_lat;
        int   waited;
        int   bad;
        exp_hit = 1'b1;
        exp_lat = op ? 23 : 16;
        for (int k = 0; k < NUM_HASH; k++) begin
            if (!model_bits[get_h(key, k)]) begin
                if (exp_hit && !op) exp_lat = 4 + 2 * k;
                exp_hit = 1'b0;
            end
        end
        mon_hit   = exp_hit;
        req_op    = op;
        req_data  = key;
        req_valid = 1'b1;
        #1;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk(req_ready, "accept_ready", req_ready, 1);
        got_hit = 1'b0;
        got_lat = -1;
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            #1;
            if (resp_valid) begin
                got_lat = n;
                break;
            end
        end
        chk(got_lat == exp_lat, "resp_latency", got_lat, exp_lat);
        got_hit = resp_hit;
        chk(got_hit == exp_hit, "resp_hit", got_hit, exp_hit);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk(resp_valid && resp_hit == exp_hit && !req_ready, "hold_stable",
                {resp_valid, resp_hit, req_ready}, {1'b1, exp_hit, 1'b0});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (op) begin
            for (int k = 0; k < NUM_HASH; k++) model_bits[get_h(key, k)] = 1'b1;
            if (model_count < 65535) model_count++;
        end
        @(negedge clk);
        #1;
        chk(insert_count == 16'(model_count), "insert_count", insert_count, model_count);
        bad = 0;
        for (int w = 0; w < NWORDS; w++)
            for (int b = 0; b < 32; b++)
                if (mem[w][b] !== model_bits[w*32 + b]) bad++;
        chk(bad == 0, "bram_contents", bad, 0);
        $display("op=%s key=%h hit=%0d lat=%0d count=%0d",
                 op ? "INS" : "QRY", key, got_hit, got_lat, insert_count);
    endtask

    initial begin
        logic [DATA_W-1:0] k0;
        logic [DATA_W-1:0] pool [6];
        logic              h;
        int                l;
        int                snap_all;
        int                snap63;
        logic              seen;

        k0 = 72'h0123456789ABCDEF;
        for (int i = 0; i < 6; i++) pool[i] = {8'($urandom), $urandom, $urandom};

        // Power-on reset and the automatic sweep.
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset_outputs");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check_sweep(1'b0);

        // Directed single-key sequence with literal expectations.
        do_op(1'b0, k0, 0, h, l);
        chk(h == 1'b0 && l == 4, "empty_query", {h, 8'(l)}, {1'b0, 8'd4});
        do_op(1'b1, k0, 0, h, l);
        chk(h == 1'b0 && l == 23 && insert_count == 16'd1, "first_insert",
            {h, 8'(l), insert_count}, {1'b0, 8'd23, 16'd1});
        do_op(1'b0, k0, 0, h, l);
        chk(h == 1'b1 && l == 16, "requery_hit", {h, 8'(l)}, {1'b1, 8'd16});
        do_op(1'b1, k0, 0, h, l);
        chk(h == 1'b1 && insert_count == 16'd2, "reinsert", {h, insert_count}, {1'b1, 16'd2});

        // Response back-pressure for ten cycles.
        do_op(1'b0, k0, 10, h, l);

        // Randomized traffic over a small key pool so repeats produce hits.
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                  int'($urandom_range(0, 3)), h, l);
        end

        // Clear and request together: clear wins, request waits for the sweep.
        @(negedge clk);
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = k0;
        #1;
        chk(!req_ready, "ready_masked_by_clear", req_ready, 0);
        @(posedge clk);
        check_sweep(1'b1);
        do_op(1'b0, k0, 0, h, l);
        chk(h == 1'b0 && l == 4, "query_after_clear", {h, 8'(l)}, {1'b0, 8'd4});

        // All hashes stubbed to the top bit: seven RMWs on the last word.
        stub     = 1'b1;
        snap_all = wr_total;
        snap63   = wr63_total;
        do_op(1'b1, pool[0], 0, h, l);
        chk(wr63_total - snap63 == 7 && wr_total - snap_all == 7, "stub_rmw_writes",
            wr63_total - snap63, 7);
        chk(mem[NWORDS-1] == 32'h80000000, "stub_final_word", mem[NWORDS-1], 32'h80000000);
        chk(h == 1'b0 && insert_count == 16'd1, "stub_insert_once",
            {h, insert_count}, {1'b0, 16'd1});
        do_op(1'b0, pool[1], 0, h, l);
        chk(h == 1'b1 && l == 16, "stub_query_hit", {h, 8'(l)}, {1'b1, 8'd16});
        stub = 1'b0;

        // Reset during a write phase abandons the insert and restarts the sweep.
        do_op(1'b1, pool[2], 0, h, l);
        @(negedge clk);
        req_op    = 1'b1;
        req_data  = pool[3];
        req_valid = 1'b1;
        #1;
        chk(req_ready, "abort_accept_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (bram_en && bram_we) seen = 1'b1;
        end
        chk(seen, "abort_reached_write", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset_outputs");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check_sweep(1'b0);
        do_op(1'b0, pool[3], 0, h, l);
        chk(h == 1'b0 && l == 4, "query_after_abort", {h, 8'(l)}, {1'b0, 8'd4});
        do_op(1'b1, pool[4], 0, h, l);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so a stuck design still reaches a verdict.
    initial begin
        #500000;
        $display("FAIL timeout: got no completion required completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
